// File: rtl/ps2_pkg.sv
// ---------------------------------------------------------------------------
// ps2_pkg
// Shared types and constants for the PS/2 keyboard front end:
//   rx_state_t   - receiver FSM state (also the debug view of the FSM)
//   SC_*         - prefix bytes and extended arrow scan codes
//   ps2_evt_t    - decoded key event {code[7:0], ext, brk}, 10 bits packed
//   arrow_mask() - maps a scan code to its bit in the held-arrow bitmap
// ---------------------------------------------------------------------------
package ps2_pkg;

    typedef enum logic [1:0] {
        RX_IDLE   = 2'd0,
        RX_DATA   = 2'd1,
        RX_PARITY = 2'd2,
        RX_STOP   = 2'd3
    } rx_state_t;

    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_BRK   = 8'hF0;
    localparam logic [7:0] SC_UP    = 8'h75;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_DOWN  = 8'h72;
    localparam logic [7:0] SC_RIGHT = 8'h74;

    typedef struct packed {
        logic [7:0] code;
        logic       ext;
        logic       brk;
    } ps2_evt_t;

    // Bitmap order is {up, left, down, right}; non-arrow codes map to 0.
    function automatic logic [3:0] arrow_mask(input logic [7:0] code);
        case (code)
            SC_UP:    arrow_mask = 4'b1000;
            SC_LEFT:  arrow_mask = 4'b0100;
            SC_DOWN:  arrow_mask = 4'b0010;
            SC_RIGHT: arrow_mask = 4'b0001;
            default:  arrow_mask = 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/ps2_evt_fifo.sv
// ---------------------------------------------------------------------------
// ps2_evt_fifo
// Synchronous show-ahead FIFO. The head entry is driven on rd_data whenever
// the FIFO is not empty (zero when empty). Writes while full are ignored
// unless a read happens in the same cycle; there is no write-to-read bypass.
// Ports:
//   clk, reset      - clock, asynchronous active-high reset
//   wr_en, wr_data  - push request and data
//   rd_en           - pop the head entry (ignored when empty)
//   rd_data         - head entry
//   full, empty     - occupancy flags
// ---------------------------------------------------------------------------
module ps2_evt_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_wr;
    logic             do_rd;

    // Pointers carry one extra wrap bit to tell full from empty.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    assign do_rd = rd_en && !empty;
    assign do_wr = wr_en && (!full || do_rd);

    assign rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr[AW-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

endmodule

// File: rtl/ps2_key_decoder.sv
// ---------------------------------------------------------------------------
// ps2_key_decoder
// PS/2 keyboard front end: synchronises and glitch-filters the raw pins,
// receives 11-bit frames with parity/stop checking and a watchdog, folds
// E0/F0 prefixes into event flags, queues events in a show-ahead FIFO and
// keeps a held-state bitmap of the four extended arrow keys.
// Ports:
//   clk, reset          - system clock, asynchronous active-high reset
//   ps2_clk, ps2_data   - raw asynchronous PS/2 pins
//   evt_valid/evt_ready - event handshake (see below)
//   evt_code/ext/brk    - head event fields
//   arrows              - held flags {up, left, down, right}
//   frame_err           - one-cycle pulse on bad frame or watchdog timeout
//   overflow            - one-cycle pulse when an event is dropped
//
// Handshake: evt_valid is high while an event sits at the FIFO head and the
// head fields are stable while it stays high. An event is consumed on every
// clock edge where evt_valid and evt_ready are both high; the next head
// event shows up in the following cycle. evt_valid never depends on
// evt_ready.
// ---------------------------------------------------------------------------
module ps2_key_decoder
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN = 8,
    parameter int TIMEOUT    = 28375,
    parameter int FIFO_DEPTH = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       evt_valid,
    input  logic       evt_ready,
    output logic [7:0] evt_code,
    output logic       evt_ext,
    output logic       evt_brk,
    output logic [3:0] arrows,
    output logic       frame_err,
    output logic       overflow
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int WW = $clog2(TIMEOUT + 1);
    localparam logic [FW-1:0] FILT_LAST  = FW'(FILTER_LEN - 1);
    localparam logic [FW-1:0] FILT_ONE   = 1;
    localparam logic [WW-1:0] WD_LIMIT   = WW'(TIMEOUT);
    localparam logic [WW-1:0] WD_ONE     = 1;

    // ---------------- input stage: index 0 = clock pin, 1 = data pin
    logic [1:0]    sync1;
    logic [1:0]    sync2;
    logic [1:0]    filt;
    logic [FW-1:0] filt_cnt [2];
    logic          filt_clk_q;
    logic          fall;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1       <= 2'b11;
            sync2       <= 2'b11;
            filt        <= 2'b11;
            filt_cnt[0] <= '0;
            filt_cnt[1] <= '0;
            filt_clk_q  <= 1'b1;
        end else begin
            sync1      <= {ps2_data, ps2_clk};
            sync2      <= sync1;
            filt_clk_q <= filt[0];
            for (int i = 0; i < 2; i++) begin
                // Any sample equal to the current level restarts the run.
                if (sync2[i] != filt[i]) begin
                    if (filt_cnt[i] == FILT_LAST) begin
                        filt[i]     <= sync2[i];
                        filt_cnt[i] <= '0;
                    end else begin
                        filt_cnt[i] <= filt_cnt[i] + FILT_ONE;
                    end
                end else begin
                    filt_cnt[i] <= '0;
                end
            end
        end
    end

    assign fall = filt_clk_q && !filt[0];

    // ---------------- receiver FSM with watchdog
    rx_state_t     state;
    logic [2:0]    bit_cnt;
    logic [7:0]    rx_shift;
    logic          rx_parity;
    logic          frame_done;
    logic          frame_ok;
    logic [WW-1:0] wd_cnt;
    logic          wd_expire;

    // A falling edge in the expiry cycle still counts as progress.
    assign wd_expire = (state != RX_IDLE) && !fall && (wd_cnt == WD_LIMIT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= RX_IDLE;
            bit_cnt    <= '0;
            rx_shift   <= '0;
            rx_parity  <= 1'b0;
            frame_done <= 1'b0;
            frame_ok   <= 1'b0;
            wd_cnt     <= '0;
        end else begin
            frame_done <= 1'b0;

            if (fall || state == RX_IDLE) begin
                wd_cnt <= '0;
            end else if (wd_cnt != WD_LIMIT) begin
                wd_cnt <= wd_cnt + WD_ONE;
            end

            if (wd_expire) begin
                state <= RX_IDLE;
            end else if (fall) begin
                case (state)
                    RX_IDLE: begin
                        if (!filt[1]) begin
                            state   <= RX_DATA;
                            bit_cnt <= '0;
                        end
                    end
                    RX_DATA: begin
                        rx_shift <= {filt[1], rx_shift[7:1]};
                        bit_cnt  <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            state <= RX_PARITY;
                        end
                    end
                    RX_PARITY: begin
                        rx_parity <= filt[1];
                        state     <= RX_STOP;
                    end
                    RX_STOP: begin
                        frame_done <= 1'b1;
                        frame_ok   <= (^{rx_shift, rx_parity}) && filt[1];
                        state      <= RX_IDLE;
                    end
                    default: state <= RX_IDLE;
                endcase
            end
        end
    end

    // ---------------- prefix folding
    logic     ext_f;
    logic     brk_f;
    logic     push_stb;
    ps2_evt_t push_evt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ext_f     <= 1'b0;
            brk_f     <= 1'b0;
            push_stb  <= 1'b0;
            push_evt  <= '0;
            frame_err <= 1'b0;
        end else begin
            push_stb  <= 1'b0;
            frame_err <= 1'b0;
            if (wd_expire || (frame_done && !frame_ok)) begin
                frame_err <= 1'b1;
                ext_f     <= 1'b0;
                brk_f     <= 1'b0;
            end else if (frame_done) begin
                // rx_shift is untouched until the next start bit's data,
                // so it still holds the finished byte here.
                if (rx_shift == SC_EXT) begin
                    ext_f <= 1'b1;
                end else if (rx_shift == SC_BRK) begin
                    brk_f <= 1'b1;
                end else begin
                    push_stb      <= 1'b1;
                    push_evt.code <= rx_shift;
                    push_evt.ext  <= ext_f;
                    push_evt.brk  <= brk_f;
                    ext_f         <= 1'b0;
                    brk_f         <= 1'b0;
                end
            end
        end
    end

    // ---------------- event FIFO, overflow and arrow bitmap
    ps2_evt_t head_evt;
    logic     fifo_full;
    logic     fifo_empty;
    logic     fifo_pop;
    logic [3:0] push_mask;

    assign evt_valid = !fifo_empty;
    assign fifo_pop  = evt_valid && evt_ready;
    assign evt_code  = head_evt.code;
    assign evt_ext   = head_evt.ext;
    assign evt_brk   = head_evt.brk;
    assign push_mask = arrow_mask(push_evt.code);

    ps2_evt_fifo #(
        .WIDTH (10),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (push_stb),
        .wr_data (push_evt),
        .rd_en   (fifo_pop),
        .rd_data (head_evt),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow <= 1'b0;
            arrows   <= '0;
        end else begin
            // A pop in the same cycle frees the slot the push needs.
            overflow <= push_stb && fifo_full && !fifo_pop;
            // The bitmap tracks key state even when the event is dropped.
            if (push_stb && push_evt.ext) begin
                if (push_evt.brk) begin
                    arrows <= arrows & ~push_mask;
                end else begin
                    arrows <= arrows | push_mask;
                end
            end
        end
    end

endmodule

// File: doc/ps2_key_decoder.md
# ps2_key_decoder

Parametrised PS/2 keyboard front end for the Minimig hardware tests and core. It turns the raw `ps2_clk`/`ps2_data` pins into a stream of decoded key events. The front end provides glitch filtering, full 11-bit frame checking with a watchdog, and E0/F0 prefix folding. Events pass through a ready/valid FIFO, and a registered held-state bitmap is kept for the four extended arrow keys. It sits in the fast clock domain, between the keyboard pins and any consumer such as the sprite or cursor logic.

## Interface
- `FILTER_LEN`, 8: consecutive equal samples required before a filtered pin level changes.
- `TIMEOUT`, 28375: idle cycles allowed between PS/2 clock falling edges mid-frame (about 1 ms at 28.375 MHz).
- `FIFO_DEPTH`, 8: event FIFO entries; must be a power of 2 and at least 2.
- `clk` input 1: system clock (`vga_clk` domain, 28.375 MHz nominal).
- `reset` input 1: asynchronous, active-high reset.
- `ps2_clk` input 1: raw PS/2 clock pin; asynchronous.
- `ps2_data` input 1: raw PS/2 data pin; asynchronous.
- `evt_valid` output 1: FIFO non-empty; head event present.
- `evt_ready` input 1: consumer accepts the head event.
- `evt_code` output 8: scan code of the head event.
- `evt_ext` output 1: head event was E0-prefixed.
- `evt_brk` output 1: head event is a release (F0-prefixed).
- `arrows` output 4: held flags {up 75, left 6B, down 72, right 74}, all extended.
- `frame_err` output 1: one-cycle pulse on a bad frame or timeout.
- `overflow` output 1: one-cycle pulse when an event is dropped because the FIFO is full.

## Operation
- **Input stage.** Each pin passes through a 2-FF synchroniser and then a filter. The filter's output toggles only after `FILTER_LEN` consecutive samples of the opposite level.
- **Bit sampling.** A bit is sampled on each falling edge of the filtered clock, taking the filtered data level.
- **Receiver FSM.** States are IDLE, DATA, PARITY, STOP.
  - IDLE: a sampled 0 is the start bit, go to DATA. A sampled 1 is ignored, stay in IDLE, no error.
  - DATA: shift in 8 bits, LSB first, then go to PARITY.
  - PARITY: capture the parity bit, go to STOP.
  - STOP: the frame is good only if parity is odd across data+parity and the stop bit is 1. Return to IDLE in either case.
- **Bad frame.** Pulse `frame_err`, discard the byte, and reset the prefix state to NONE.
- **Watchdog.** The counter clears on every falling edge and counts while the FSM is not IDLE. When it reaches `TIMEOUT`, the FSM aborts to IDLE, `frame_err` pulses, and the prefix state resets.
- **Prefix folding.** The `ext` and `brk` flags are independent.
  - Byte E0 sets `ext`.
  - Byte F0 sets `brk`.
  - Any other byte emits the event {byte, `ext`, `brk`} and clears both flags.
  - E1, AA, FA and FE are emitted as ordinary codes.
- **Arrow bitmap.** An emitted event with `ext`=1 and an arrow code sets that arrow bit on make and clears it on break. This is independent of FIFO space.
- **FIFO.**
  - Show-ahead: the head event is presented on `evt_code`, `evt_ext` and `evt_brk` while `evt_valid` is high.
  - A pop happens when `evt_valid` and `evt_ready` are both high.
  - Push while full with no pop: the event is dropped and `overflow` pulses.
  - Push and pop in the same cycle while full: both proceed, no overflow.
  - Push and pop in the same cycle while empty: no bypass; the event appears on the next cycle.
- **Reset values.** Outputs go to `evt_valid`=0, `evt_code`=00, `evt_ext`=0, `evt_brk`=0, `arrows`=0000, `frame_err`=0, `overflow`=0. Internally the FIFO is empty, the FSM is IDLE, prefix is NONE, filtered pins are 1 and counters are 0. Reset mid-frame discards the partial frame.

## Timing
- Pin to filtered level: 2 + `FILTER_LEN` cycles.
- Stop bit sampled at edge cycle N:
  - N+1: frame check and prefix update.
  - N+1: `frame_err` pulse, if the frame is bad.
  - N+2: FIFO write visible; `evt_valid` is high if the FIFO was empty; `arrows` updated; `overflow` pulses if applicable.
- Timeout: `frame_err` pulses in the cycle after the counter equals `TIMEOUT`.
- After a pop, the next head event appears in the following cycle.
- `frame_err` and `overflow` are strictly single-cycle pulses.

## Structure
- Shared package `ps2_pkg`:
  - receiver state enum;
  - constants `SC_EXT`=E0, `SC_BRK`=F0, `SC_UP`=75, `SC_LEFT`=6B, `SC_DOWN`=72, `SC_RIGHT`=74;
  - a packed event struct {code[7:0], ext, brk}.
- Sub-module `ps2_evt_fifo`: a generic synchronous show-ahead FIFO, 10 bits wide, `FIFO_DEPTH` deep, with full/empty flags.
- Synchroniser, filter, receiver, prefix decoder and bitmap stay in the top module.

## Test plan
- **Valid make code.** Send byte 1C with parity 0 (odd) and stop 1 -> exactly one event {1C,0,0}; `arrows`=0000; no `frame_err`.
- **Extended arrow press/release.** Send E0 75 -> event {75,1,0} and `arrows`=1000. Then send E0 F0 75 -> event {75,1,1} and `arrows`=0000.
- **Parity error.** Send 1C with parity 1 -> one `frame_err` pulse and no event. The next valid 6B decodes as {6B,0,0}.
- **Watchdog.** Stop `ps2_clk` after 4 data bits and wait `TIMEOUT`+2 cycles -> one `frame_err` pulse. A following full frame for 29 decodes correctly.
- **Overflow.** Hold `evt_ready`=0 and send `FIFO_DEPTH`+1 make codes 01..09 -> `overflow` pulses once, on 09. Releasing `evt_ready` drains 01..08 in order.
- **Glitch rejection and reset.** A `ps2_clk` low glitch of `FILTER_LEN`-1 cycles samples no bit. Asserting `reset` mid-frame -> all outputs return to reset values and the next frame decodes cleanly.
